hazard_control_unit: RTL

Central pipeline-control block for the five-stage core, sitting beside the EX-stage forwarding logic. It handles every hazard that operand forwarding cannot resolve: load-use dependencies, taken-branch flushes and multi-cycle data-memory waits. It drives per-stage enable and flush signals for the IF/ID, ID/EX, EX/ME and ME/WB pipeline registers. It also tracks a memory-wait timeout with a sticky error state.

---
 rtl/hazard_control_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze with timeout.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
//   state   | meaning
//   RUN     | normal issue, hazards resolved by priority
//   MEMWAIT | frozen on an outstanding data-memory access
//   MEMERR  | memory timeout, frozen until reset
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_use_rs1,
  input  logic             de_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_dmrd,
  input  logic             ex_brtaken,
  input  logic             me_dmreq,
  input  logic             me_dmack,
  output logic             if_pcwr,
  output logic             de_en,
  output logic             ex_en,
  output logic             me_en,
  output logic             de_flush,
  output logic             ex_flush,
  output logic             wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] perf_ldstall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_memwait
);

  typedef enum logic [1:0] {RUN, MEMWAIT, MEMERR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       ldhaz, memfrz;
  logic       act_frz, act_br, act_ld, act_err;

  assign ldhaz  = ex_dmrd && (ex_rd != 5'd0) &&
                  ((de_use_rs1 && (ex_rd == de_rs1)) || (de_use_rs2 && (ex_rd == de_rs2)));
  assign memfrz = me_dmreq && !me_dmack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    act_frz    = 1'b0;
    act_br     = 1'b0;
    act_ld     = 1'b0;
    act_err    = 1'b0;
    case (state_q)
      RUN: begin
        if (memfrz) begin
          act_frz    = 1'b1;
          state_d    = MEMWAIT;
          wait_cnt_d = 8'd1;
        end else if (ex_brtaken) begin
          act_br = 1'b1;
        end else if (ldhaz) begin
          act_ld = 1'b1;
        end
      end
      MEMWAIT: begin
        if (me_dmack) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          if (ex_brtaken)  act_br = 1'b1;
          else if (ldhaz)  act_ld = 1'b1;
        end else begin
          // wait_cnt counts freeze cycles already spent; the one ending now is the next
          act_frz    = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q + 8'd1 == TIMEOUT) state_d = MEMERR;
        end
      end
      MEMERR: begin
        act_frz = 1'b1;
        act_err = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    if_pcwr   = 1'b1;
    de_en     = 1'b1;
    ex_en     = 1'b1;
    me_en     = 1'b1;
    de_flush  = 1'b0;
    ex_flush  = 1'b0;
    wb_bubble = 1'b0;
    mem_err   = 1'b0;
    if (rst) begin
      if_pcwr   = 1'b0;
      de_en     = 1'b0;
      ex_en     = 1'b0;
      me_en     = 1'b0;
      de_flush  = 1'b1;
      ex_flush  = 1'b1;
      wb_bubble = 1'b1;
    end else if (act_frz) begin
      if_pcwr   = 1'b0;
      de_en     = 1'b0;
      ex_en     = 1'b0;
      me_en     = 1'b0;
      wb_bubble = 1'b1;
      mem_err   = act_err;
    end else begin
      if_pcwr  = !act_ld;
      de_en    = !act_ld;
      de_flush = act_br;
      ex_flush = act_br || act_ld;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ldstall <= '0;
      perf_flush   <= '0;
      perf_memwait <= '0;
    end else begin
      if (act_ld  && perf_ldstall != CNT_MAX) perf_ldstall <= perf_ldstall + 1'b1;
      if (act_br  && perf_flush   != CNT_MAX) perf_flush   <= perf_flush + 1'b1;
      if (act_frz && perf_memwait != CNT_MAX) perf_memwait <= perf_memwait + 1'b1;
    end
  end
`else
  assign perf_ldstall = '0;
  assign perf_flush   = '0;
  assign perf_memwait = '0;
`endif

endmodule
